// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: 2-wide dispatch, 3 completion ports, 2-wide retire.
// Drives the RRF/ARF commit pairs and raises flush_out on a retiring mispredict.
module rob_commit_unit #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             disp_valid1,
    input  logic             disp_has_dest1,
    input  logic [2:0]       disp_arch_idx1,
    input  logic [TAG_W-1:0] disp_rrf_tag1,
    input  logic             disp_valid2,
    input  logic             disp_has_dest2,
    input  logic [2:0]       disp_arch_idx2,
    input  logic [TAG_W-1:0] disp_rrf_tag2,
    output logic             rob_ready,
    output logic [IDX_W-1:0] disp_rob_idx1,
    output logic [IDX_W-1:0] disp_rob_idx2,
    input  logic             cmp1_en,
    input  logic [IDX_W-1:0] cmp1_idx,
    input  logic             cmp1_mispredict,
    input  logic             cmp2_en,
    input  logic [IDX_W-1:0] cmp2_idx,
    input  logic             cmp2_mispredict,
    input  logic             cmp3_en,
    input  logic [IDX_W-1:0] cmp3_idx,
    input  logic             cmp3_mispredict,
    output logic             rob_write_valid1,
    output logic [2:0]       rob_write_index1,
    output logic [TAG_W-1:0] rob_rrf_read_idx1,
    output logic             rob_write_valid2,
    output logic [2:0]       rob_write_index2,
    output logic [TAG_W-1:0] rob_rrf_read_idx2,
    output logic [1:0]       retire_count,
    output logic             flush_out
);
    logic [DEPTH-1:0] valid, done, mispredict, has_dest;
    logic [2:0]       arch_idx [DEPTH];
    logic [TAG_W-1:0] rrf_tag [DEPTH];
    logic [IDX_W-1:0] head, tail, head1, tail1;
    logic [IDX_W:0]   count;
    logic             clear, c1, c2, take1, take2;
    logic [1:0]       n_disp;
    logic [DEPTH-1:0] cmp_hit, cmp_mis, retire_clr;

    assign clear = reset | flush;
    assign head1 = head + IDX_W'(1);
    assign tail1 = tail + IDX_W'(1);

    assign rob_ready     = count <= (IDX_W+1)'(DEPTH - 2);
    assign disp_rob_idx1 = tail;
    assign disp_rob_idx2 = tail1;
    assign take1  = rob_ready & disp_valid1;
    assign take2  = take1 & disp_valid2;
    assign n_disp = {1'b0, take1} + {1'b0, take2};

    // Second slot may not retire behind a mispredicted head.
    assign c1 = ~clear & valid[head] & done[head];
    assign c2 = c1 & ~mispredict[head] & valid[head1] & done[head1];

    assign flush_out         = (c1 & mispredict[head]) | (c2 & mispredict[head1]);
    assign rob_write_valid1  = c1 & has_dest[head];
    assign rob_write_index1  = c1 ? arch_idx[head] : '0;
    assign rob_rrf_read_idx1 = c1 ? rrf_tag[head] : '0;
    assign rob_write_valid2  = c2 & has_dest[head1];
    assign rob_write_index2  = c2 ? arch_idx[head1] : '0;
    assign rob_rrf_read_idx2 = c2 ? rrf_tag[head1] : '0;
    assign retire_count      = {1'b0, c1} + {1'b0, c2};

    // Ports naming the same entry merge their mispredict bits here.
    always_comb begin
        cmp_hit    = '0;
        cmp_mis    = '0;
        retire_clr = '0;
        if (cmp1_en) begin
            cmp_hit[cmp1_idx] = 1'b1;
            cmp_mis[cmp1_idx] = cmp_mis[cmp1_idx] | cmp1_mispredict;
        end
        if (cmp2_en) begin
            cmp_hit[cmp2_idx] = 1'b1;
            cmp_mis[cmp2_idx] = cmp_mis[cmp2_idx] | cmp2_mispredict;
        end
        if (cmp3_en) begin
            cmp_hit[cmp3_idx] = 1'b1;
            cmp_mis[cmp3_idx] = cmp_mis[cmp3_idx] | cmp3_mispredict;
        end
        cmp_hit = cmp_hit & valid;
        if (c1) retire_clr[head] = 1'b1;
        if (c2) retire_clr[head1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clear | flush_out) begin
            valid      <= '0;
            done       <= '0;
            mispredict <= '0;
            has_dest   <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                arch_idx[i] <= '0;
                rrf_tag[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cmp_hit[i]) begin
                    done[i]       <= 1'b1;
                    mispredict[i] <= mispredict[i] | cmp_mis[i];
                end
                if (retire_clr[i]) begin
                    valid[i]      <= 1'b0;
                    done[i]       <= 1'b0;
                    mispredict[i] <= 1'b0;
                    has_dest[i]   <= 1'b0;
                end
            end
            // Dispatch targets free entries only, so it never collides with retire.
            if (take1) begin
                valid[tail]      <= 1'b1;
                done[tail]       <= 1'b0;
                mispredict[tail] <= 1'b0;
                has_dest[tail]   <= disp_has_dest1;
                arch_idx[tail]   <= disp_arch_idx1;
                rrf_tag[tail]    <= disp_rrf_tag1;
            end
            if (take2) begin
                valid[tail1]      <= 1'b1;
                done[tail1]       <= 1'b0;
                mispredict[tail1] <= 1'b0;
                has_dest[tail1]   <= disp_has_dest2;
                arch_idx[tail1]   <= disp_arch_idx2;
                rrf_tag[tail1]    <= disp_rrf_tag2;
            end
            head  <= head + IDX_W'(retire_count);
            tail  <= tail + IDX_W'(n_disp);
            count <= count + (IDX_W+1)'(n_disp) - (IDX_W+1)'(retire_count);
        end
    end
endmodule
